reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor of the decode-stage register file for the beta pipeline.
- Provides NRD read ports with generic N-stage bypass, a write-through write port and a hardwired zero register.
- Adds a pending-write scoreboard for long-latency results (LD/LDR, multi-cycle units) and a saturating stall-cycle counter.
- Sits in decode: reads operands, forwards from later stages, and drives the pipeline stall.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of architectural registers (power of 2).
- NRD, 2, number of read ports.
- NBYP, 3, number of bypass stages (index 0 = youngest, e.g. exec; NBYP-1 = oldest, e.g. wb).
- ZERO_REG, 31, register that reads 0 and ignores writes.
- CNTW, 16, width of the stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rd_en  in  NRD  read port r needs its operand (gates hazard checks)
- ra  in  NRD*$clog2(NREGS)  read addresses
- rd  out  NRD*XLEN  read data
- we  in  1  write enable
- wa  in  $clog2(NREGS)  write address
- wd  in  XLEN  write data
- byp_valid  in  NBYP  stage i holds an instruction writing byp_addr[i]
- byp_ready  in  NBYP  stage i result is available (0 for a load before wb)
- byp_addr  in  NBYP*$clog2(NREGS)  destination register per stage
- byp_data  in  NBYP*XLEN  result per stage
- sb_set  in  1  a long-latency op issues; mark sb_addr pending
- sb_addr  in  $clog2(NREGS)  destination of the issuing op
- sb_clr  in  1  long-latency result retires; clear pending on wa (coincides with we)
- stall  out  1  decode must hold
- pending  out  NREGS  scoreboard bits (debug/verification)
- stall_cnt  out  CNTW  saturating count of stalled cycles

Behaviour:
- Reset (async, rst=1):
  - all NREGS registers = 0, pending = 0, stall_cnt = 0.
  - stall forced to 0 while rst=1.
- Write: on posedge clk, if we && wa != ZERO_REG then reg[wa] <= wd.
- Read port r (combinational, zero latency). The first matching rule wins:
  1. ra[r] == ZERO_REG -> 0, no hazard.
  2. Lowest i with byp_valid[i] && byp_addr[i] == ra[r]:
     - if byp_ready[i], rd = byp_data[i];
     - else hazard. Data is don't-care; stall covers it.
     - A younger stage always shadows an older one.
  3. we && wa == ra[r] -> wd (write-through).
  4. pending[ra[r]] -> hazard.
  5. Otherwise rd = reg[ra[r]].
  - byp_valid with byp_addr == ZERO_REG never matches.
- stall = OR over r of (rd_en[r] && hazard[r]).
  - A port with rd_en=0 never stalls. This replaces the old opcode-class gating for Rb/ST.
- Scoreboard, on posedge clk:
  - sb_clr clears pending[wa].
  - sb_set sets pending[sb_addr].
  - Same address, same cycle: the set wins, because the newer op owns the register.
  - sb_set with sb_addr == ZERO_REG is ignored.
  - sb_set is sampled even while stall=1. Upstream guarantees it only fires for an op actually leaving decode.
- stall_cnt increments each cycle stall=1 and saturates at all-ones. It never wraps.
- Reset mid-operation: pending and in-flight bypasses are discarded, and the register array clears.
- All outputs depend only on current inputs and state. There are no combinational loops through stall.

Decomposition:
- reg_file_pkg holds:
  - localparams AW = $clog2(NREGS) and ZERO_REG default;
  - typedef reg_addr_t (logic [AW-1:0]);
  - typedef byp_t struct {valid, ready, addr, data}.
- Sub-module reg_file_rd_port handles one read port: the priority bypass mux plus hazard flag. It is instantiated NRD times via generate.
- The top level holds the array, the scoreboard, the stall OR-reduction and the counter.

Test Plan:
- Reset clears state: write r5=0x1234, then assert rst mid-cycle -> rd for r5 = 0, pending = 0 and stall_cnt = 0 immediately (async).
- Bypass priority: byp_valid = 3'b111, all addr=3, data = 0xA, 0xB, 0xC, all ready -> rd[0] for ra=3 is 0xA. Drop stage 0 -> 0xB.
- Load-use stall:
  - stage 1 valid, addr=7, ready=0, ra[1]=7, rd_en[1]=1 -> stall=1.
  - Same with rd_en[1]=0 -> stall=0.
- Scoreboard:
  - sb_set on r9 -> pending[9]=1, and a read of r9 stalls.
  - Then we=1, wa=9, wd=0x55, sb_clr=1 -> same-cycle read returns 0x55 with no stall, and pending[9]=0 next cycle.
  - Simultaneous sb_set and sb_clr on r9 -> pending[9] stays 1.
- Zero register: we=1, wa=31, wd=0xFFFF_FFFF and sb_set on 31 -> a read of r31 returns 0, no stall, pending[31]=0.
- Counter saturation: with CNTW=4, hold a hazard for 20 cycles -> stall_cnt = 15 and stays at 15.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and default geometry for the decode-stage register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NREGS_DEF    = 32;
    localparam int AW           = $clog2(NREGS_DEF);
    localparam int ZERO_REG_DEF = 31;

    typedef logic [AW-1:0] reg_addr_t;

    // One bypass stage as seen by decode at the default geometry.
    typedef struct packed {
        logic               valid;
        logic               ready;
        reg_addr_t          addr;
        logic [XLEN_DEF-1:0] data;
    } byp_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One operand read port: zero register, priority bypass, write-through, scoreboard hazard.
// Latency: purely combinational, zero cycles.
// Backpressure: raises hazard when the operand is not yet available; the top turns it into stall.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NBYP     = 3,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int ADDR_W   = $clog2(NREGS)
) (
    input  logic [ADDR_W-1:0]      ra,
    input  logic [NBYP-1:0]        byp_valid,
    input  logic [NBYP-1:0]        byp_ready,
    input  logic [NBYP*ADDR_W-1:0] byp_addr,
    input  logic [NBYP*XLEN-1:0]   byp_data,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      wa,
    input  logic [XLEN-1:0]        wd,
    input  logic                   is_pending,
    input  logic [XLEN-1:0]        reg_data,
    output logic [XLEN-1:0]        rd,
    output logic                   hazard
);

    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic matched;

    // Priority selection: zero reg, youngest matching bypass, write-through, scoreboard, array.
    always_comb begin
        rd      = reg_data;
        hazard  = 1'b0;
        matched = 1'b0;
        if (ra == ZADDR) begin
            rd = '0;
        end else begin
            // ra is not the zero register here, so a bypass aimed at it can never match.
            for (int i = 0; i < NBYP; i++) begin
                if (!matched && byp_valid[i] && (byp_addr[i*ADDR_W +: ADDR_W] == ra)) begin
                    matched = 1'b1;
                    if (byp_ready[i]) begin
                        rd = byp_data[i*XLEN +: XLEN];
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
            if (!matched) begin
                if (we && (wa == ra)) begin
                    rd = wd;
                end else if (is_pending) begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Decode register file with N-stage bypass, write-through, pending-write scoreboard and stall counter.
// Latency: reads combinational; writes, scoreboard and counter update on the next clk edge.
// Backpressure: stall asserts when any enabled read port has an unavailable operand.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NBYP     = 3,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int CNTW     = 16,
    parameter int ADDR_W   = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*ADDR_W-1:0]  ra,
    output logic [NRD*XLEN-1:0]    rd,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      wa,
    input  logic [XLEN-1:0]        wd,
    input  logic [NBYP-1:0]        byp_valid,
    input  logic [NBYP-1:0]        byp_ready,
    input  logic [NBYP*ADDR_W-1:0] byp_addr,
    input  logic [NBYP*XLEN-1:0]   byp_data,
    input  logic                   sb_set,
    input  logic [ADDR_W-1:0]      sb_addr,
    input  logic                   sb_clr,
    output logic                   stall,
    output logic [NREGS-1:0]       pending,
    output logic [CNTW-1:0]        stall_cnt
);

    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NRD-1:0]   hazard;
    logic [CNTW-1:0]  cnt_q;

    // Architectural register array; the zero register is never written so it stays 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != ZADDR)) begin
            regs[wa] <= wd;
        end
    end

    // Scoreboard next state: retire clears first so an issuing op to the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (sb_clr) begin
            pending_d[wa] = 1'b0;
        end
        if (sb_set && (sb_addr != ZADDR)) begin
            pending_d[sb_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [ADDR_W-1:0] ra_r;
        assign ra_r = ra[r*ADDR_W +: ADDR_W];

        reg_file_rd_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .NBYP     (NBYP),
            .ZERO_REG (ZERO_REG),
            .ADDR_W   (ADDR_W)
        ) u_port (
            .ra         (ra_r),
            .byp_valid  (byp_valid),
            .byp_ready  (byp_ready),
            .byp_addr   (byp_addr),
            .byp_data   (byp_data),
            .we         (we),
            .wa         (wa),
            .wd         (wd),
            .is_pending (pending_q[ra_r]),
            .reg_data   (regs[ra_r]),
            .rd         (rd[r*XLEN +: XLEN]),
            .hazard     (hazard[r])
        );
    end

    // Only ports that actually consume an operand may hold decode; reset masks stall outright.
    assign stall = ~rst & (|(rd_en & hazard));

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign pending   = pending_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with an expectation queue drained at each sample point.
// Latency: samples combinational outputs 1-2 ns after input changes, registered ones 1 ns after clk.
// Backpressure: stall is observed as a plain output.
module tb_reg_file_sb;

    localparam int AWT = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   rd_en = '0;
    logic [9:0]   ra = '0;
    logic [63:0]  rd;
    logic         we = 1'b0;
    logic [4:0]   wa = '0;
    logic [31:0]  wd = '0;
    logic [2:0]   byp_valid = '0;
    logic [2:0]   byp_ready = '0;
    logic [14:0]  byp_addr = '0;
    logic [95:0]  byp_data = '0;
    logic         sb_set = 1'b0;
    logic [4:0]   sb_addr = '0;
    logic         sb_clr = 1'b0;
    logic         stall;
    logic [31:0]  pending;
    logic [3:0]   stall_cnt;

    int checks   = 0;
    int failures = 0;

    string       tag_q [$];
    int          sel_q [$];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    reg_file_sb #(.CNTW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .ra        (ra),
        .rd        (rd),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .byp_valid (byp_valid),
        .byp_ready (byp_ready),
        .byp_addr  (byp_addr),
        .byp_data  (byp_data),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .sb_clr    (sb_clr),
        .stall     (stall),
        .pending   (pending),
        .stall_cnt (stall_cnt)
    );

    // sel: 0 rd port0, 1 rd port1, 2 stall, 3 pending, 4 stall_cnt
    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    task automatic settle_and_check();
        string       t;
        int          s;
        logic [31:0] e;
        logic [31:0] o;
        #1;
        while (sel_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            case (s)
                0:       o = rd[31:0];
                1:       o = rd[63:32];
                2:       o = {31'b0, stall};
                3:       o = pending;
                default: o = {28'b0, stall_cnt};
            endcase
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", t, o, e);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byp(input int i, input logic [4:0] a, input logic [31:0] d);
        byp_addr[i*AWT +: AWT] = a;
        byp_data[i*32 +: 32]   = d;
    endtask

    initial begin
        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        expect_val("rst_stall", 2, 32'h0);
        expect_val("rst_pending", 3, 32'h0);
        expect_val("rst_cnt", 4, 32'h0);
        settle_and_check();
        rst = 1'b0;

        // Write r5, issue long-latency op to r9
        next_cycle();
        we = 1'b1; wa = 5'd5; wd = 32'h1234;
        sb_set = 1'b1; sb_addr = 5'd9;
        next_cycle();
        we = 1'b0; sb_set = 1'b0;
        ra[4:0] = 5'd5;
        expect_val("wr_r5", 0, 32'h1234);
        expect_val("sb_r9_set", 3, 32'h0000_0200);
        settle_and_check();

        // Un-ready bypass on r5 stalls port 0, counted on the next edge
        byp_valid = 3'b001; byp_ready = 3'b000; set_byp(0, 5'd5, 32'hDEAD);
        rd_en = 2'b01;
        expect_val("byp_hazard_stall", 2, 32'h1);
        settle_and_check();
        next_cycle();
        expect_val("cnt_one", 4, 32'h1);
        settle_and_check();

        // Asynchronous reset mid-cycle, hazard still presented
        rst = 1'b1;
        expect_val("arst_stall", 2, 32'h0);
        expect_val("arst_pending", 3, 32'h0);
        expect_val("arst_cnt", 4, 32'h0);
        settle_and_check();
        byp_valid = 3'b000;
        expect_val("arst_r5", 0, 32'h0);
        settle_and_check();
        @(negedge clk);
        rst = 1'b0;
        rd_en = 2'b00;

        // Bypass priority, youngest first
        next_cycle();
        byp_valid = 3'b111; byp_ready = 3'b111;
        set_byp(0, 5'd3, 32'hA); set_byp(1, 5'd3, 32'hB); set_byp(2, 5'd3, 32'hC);
        ra[4:0] = 5'd3;
        expect_val("byp_s0", 0, 32'hA);
        settle_and_check();
        byp_valid = 3'b110;
        expect_val("byp_s1", 0, 32'hB);
        settle_and_check();
        byp_valid = 3'b100;
        expect_val("byp_s2", 0, 32'hC);
        settle_and_check();
        // Younger not-ready stage shadows ready older stages
        byp_valid = 3'b111; byp_ready = 3'b110; rd_en = 2'b01;
        expect_val("byp_young_shadow", 2, 32'h1);
        settle_and_check();
        byp_valid = 3'b000; rd_en = 2'b00;
        // Write-through on port 1
        we = 1'b1; wa = 5'd4; wd = 32'h77; ra[9:5] = 5'd4;
        expect_val("wr_through_p1", 1, 32'h77);
        expect_val("reg_r3_empty", 0, 32'h0);
        settle_and_check();
        next_cycle();
        we = 1'b0;
        expect_val("r4_stored", 1, 32'h77);
        settle_and_check();

        // Load-use: stage 1 not ready on r7
        byp_valid = 3'b010; byp_ready = 3'b000; set_byp(1, 5'd7, 32'h0);
        ra[9:5] = 5'd7; rd_en = 2'b10;
        expect_val("load_use_stall", 2, 32'h1);
        settle_and_check();
        rd_en = 2'b00;
        expect_val("load_use_rd_en0", 2, 32'h0);
        settle_and_check();
        byp_valid = 3'b000;

        // Scoreboard set / clear with write-through
        next_cycle();
        sb_set = 1'b1; sb_addr = 5'd9;
        next_cycle();
        sb_set = 1'b0;
        ra[4:0] = 5'd9; rd_en = 2'b01;
        expect_val("sb_pending9", 3, 32'h0000_0200);
        expect_val("sb_stall9", 2, 32'h1);
        settle_and_check();
        we = 1'b1; wa = 5'd9; wd = 32'h55; sb_clr = 1'b1;
        expect_val("sb_retire_rd", 0, 32'h55);
        expect_val("sb_retire_nostall", 2, 32'h0);
        settle_and_check();
        next_cycle();
        we = 1'b0; sb_clr = 1'b0;
        expect_val("sb_cleared", 3, 32'h0);
        expect_val("r9_stored", 0, 32'h55);
        settle_and_check();
        // Set and clear collide on r9: set wins
        sb_set = 1'b1; sb_addr = 5'd9;
        next_cycle();
        we = 1'b1; wa = 5'd9; wd = 32'h66; sb_clr = 1'b1;
        next_cycle();
        sb_set = 1'b0;
        expect_val("sb_set_wins", 3, 32'h0000_0200);
        settle_and_check();
        next_cycle();
        we = 1'b0; sb_clr = 1'b0;
        expect_val("sb_clear_again", 3, 32'h0);
        settle_and_check();

        // Zero register ignores writes, scoreboard and bypass
        we = 1'b1; wa = 5'd31; wd = 32'hFFFF_FFFF;
        sb_set = 1'b1; sb_addr = 5'd31;
        byp_valid = 3'b001; byp_ready = 3'b000; set_byp(0, 5'd31, 32'h1);
        ra[4:0] = 5'd31; rd_en = 2'b01;
        expect_val("zero_rd_wt", 0, 32'h0);
        expect_val("zero_nostall", 2, 32'h0);
        settle_and_check();
        next_cycle();
        we = 1'b0; sb_set = 1'b0; byp_valid = 3'b000;
        expect_val("zero_pending", 3, 32'h0);
        expect_val("zero_rd_after", 0, 32'h0);
        settle_and_check();

        // Counter saturation
        byp_valid = 3'b001; byp_ready = 3'b000; set_byp(0, 5'd7, 32'h0);
        ra[4:0] = 5'd7; rd_en = 2'b01;
        repeat (20) next_cycle();
        expect_val("cnt_sat", 4, 32'hF);
        expect_val("cnt_sat_stall", 2, 32'h1);
        settle_and_check();
        next_cycle();
        expect_val("cnt_sat_hold", 4, 32'hF);
        settle_and_check();
        byp_valid = 3'b000;
        next_cycle();
        expect_val("cnt_after_release", 4, 32'hF);
        expect_val("stall_released", 2, 32'h0);
        settle_and_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
